// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and receive FIFO.
package uart_pkg;

    localparam int UART_SAMPLES_PER_BIT  = 16;
    localparam int UART_BITS_PER_CHAR    = 10;
    localparam int UART_SAMPLES_PER_CHAR = UART_SAMPLES_PER_BIT * UART_BITS_PER_CHAR;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_idle_timer.sv
// Saturating idle counter advanced by the 16x sample tick; expired_o marks the limit.
module uart_idle_timer #(
    parameter int LIMIT = 640
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clken_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (clken_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through output, sticky overflow and idle timeout.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clken_i,
    input  logic [7:0]             din_8b_i,
    input  logic                   din_valid_i,
    output logic [7:0]             dout_8b_o,
    output logic                   dout_valid_o,
    input  logic                   dout_ready_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    input  logic                   overflow_clr_i,
    output logic                   timeout_o
);

    localparam int PTR_W         = $clog2(DEPTH);
    localparam int CNT_W         = PTR_W + 1;
    localparam int TIMEOUT_LIMIT = TIMEOUT_CHARS * UART_SAMPLES_PER_CHAR;

    uart_byte_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic idle_expired;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign pop   = !empty && dout_ready_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push  = din_valid_i && (!full || pop);
    assign drop  = din_valid_i && full && !pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gating keeps stale entries invisible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din_8b_i;
        end
    end

    uart_idle_timer #(
        .LIMIT (TIMEOUT_LIMIT)
    ) u_idle_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clken_i   (clken_i),
        .clr_i     (push || pop || empty),
        .expired_o (idle_expired)
    );

    assign dout_8b_o    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign dout_valid_o = !empty;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign timeout_o    = idle_expired && !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, wrap, overflow, idle timeout and reset.
module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clken_i = 1'b0;
    logic [7:0] din_8b_i = 8'h00;
    logic       din_valid_i = 1'b0;
    logic [7:0] dout_8b_o;
    logic       dout_valid_o;
    logic       dout_ready_i = 1'b0;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       overflow_clr_i = 1'b0;
    logic       timeout_o;

    int n_vec    = 0;
    int n_miscmp = 0;

    logic [3:0] div = 4'd0;

    uart_rx_fifo #(
        .DEPTH         (16),
        .TIMEOUT_CHARS (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clken_i        (clken_i),
        .din_8b_i       (din_8b_i),
        .din_valid_i    (din_valid_i),
        .dout_8b_o      (dout_8b_o),
        .dout_valid_o   (dout_valid_o),
        .dout_ready_i   (dout_ready_i),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // One-cycle sample tick every 16 clocks, changed away from the active edge.
    always @(negedge clk_i) begin
        div     = div + 4'd1;
        clken_i = (div == 4'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        din_8b_i    = b;
        din_valid_i = 1'b1;
        step();
        din_valid_i = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, {31'd0, dout_valid_o} << 8 | {24'd0, dout_8b_o}, {23'd0, 1'b1, exp});
        dout_ready_i = 1'b1;
        step();
        dout_ready_i = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int ticks = 0;
        int cyc   = 0;
        while (ticks < n && cyc < n * 16 + 64) begin
            @(posedge clk_i);
            if (clken_i) ticks++;
            cyc++;
        end
        #1;
        check("tick_budget", ticks, n);
    endtask

    initial begin
        // Reset state
        step();
        rst_i = 1'b0;
        check("rst_count", count_o, 0);
        check("rst_valid", dout_valid_o, 0);
        check("rst_data", dout_8b_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_tmo", timeout_o, 0);

        // Two bytes, first-word-fall-through
        push_byte(8'hA5);
        check("fwft_count1", count_o, 1);
        check("fwft_data1", dout_8b_o, 8'hA5);
        push_byte(8'h3C);
        check("two_count", count_o, 2);
        check("two_head", dout_8b_o, 8'hA5);
        pop_expect("two_pop0", 8'hA5);
        check("two_next", dout_8b_o, 8'h3C);
        check("two_count_after", count_o, 1);
        pop_expect("two_pop1", 8'h3C);
        check("two_empty", dout_valid_o, 0);

        // Fill, drop one, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check("full_count", count_o, 16);
        check("full_ovf_clean", overflow_o, 0);
        push_byte(8'hFF);
        check("drop_ovf", overflow_o, 1);
        check("drop_count", count_o, 16);
        for (int i = 0; i < 16; i++) pop_expect("drain_data", 8'(i));
        check("drain_count", count_o, 0);
        check("drain_data_zero", dout_8b_o, 0);
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        check("clr_ovf", overflow_o, 0);

        // 20 bytes streamed across the pointer wrap, eight in flight
        for (int i = 0; i < 20; i++) begin
            din_8b_i    = 8'(8'h40 + i);
            din_valid_i = 1'b1;
            if (i >= 8) begin
                check("wrap_head", dout_8b_o, 8'(8'h40 + i - 8));
                dout_ready_i = 1'b1;
            end
            step();
        end
        din_valid_i  = 1'b0;
        dout_ready_i = 1'b0;
        check("wrap_count", count_o, 8);
        for (int i = 12; i < 20; i++) pop_expect("wrap_drain", 8'(8'h40 + i));
        check("wrap_empty", count_o, 0);

        // Full FIFO, push and pop together
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        check("pp_head", dout_8b_o, 8'h80);
        din_8b_i     = 8'h77;
        din_valid_i  = 1'b1;
        dout_ready_i = 1'b1;
        step();
        din_valid_i  = 1'b0;
        dout_ready_i = 1'b0;
        check("pp_count", count_o, 16);
        check("pp_ovf", overflow_o, 0);
        for (int i = 1; i < 16; i++) pop_expect("pp_drain", 8'(8'h80 + i));
        pop_expect("pp_last", 8'h77);
        check("pp_empty", dout_valid_o, 0);

        // Idle timeout on one held byte
        push_byte(8'h5A);
        wait_ticks(639);
        check("tmo_639", timeout_o, 0);
        wait_ticks(1);
        check("tmo_640", timeout_o, 1);
        pop_expect("tmo_pop", 8'h5A);
        check("tmo_clear", timeout_o, 0);
        check("tmo_empty", dout_valid_o, 0);

        // Overflow set wins over clear
        for (int i = 0; i < 17; i++) push_byte(8'(8'hC0 + i));
        check("ovf_set", overflow_o, 1);
        din_8b_i       = 8'hEE;
        din_valid_i    = 1'b1;
        overflow_clr_i = 1'b1;
        step();
        din_valid_i    = 1'b0;
        check("ovf_set_wins", overflow_o, 1);
        step();
        overflow_clr_i = 1'b0;
        check("ovf_clear_alone", overflow_o, 0);

        // Reset with traffic and a pending timeout
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i));
        wait_ticks(640);
        check("rst_pre_tmo", timeout_o, 1);
        check("rst_pre_count", count_o, 5);
        rst_i       = 1'b1;
        din_8b_i    = 8'hEE;
        din_valid_i = 1'b1;
        step();
        rst_i       = 1'b0;
        din_valid_i = 1'b0;
        check("rst2_count", count_o, 0);
        check("rst2_valid", dout_valid_o, 0);
        check("rst2_data", dout_8b_o, 0);
        check("rst2_ovf", overflow_o, 0);
        check("rst2_tmo", timeout_o, 0);
        step();
        check("rst2_still_empty", dout_valid_o, 0);
        push_byte(8'h11);
        check("rst2_new_count", count_o, 1);
        pop_expect("rst2_new_data", 8'h11);
        check("rst2_final_empty", dout_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
